// File: rtl/host_bus_bridge.sv
// Host command adapter for the crypto coprocessor register file: turns 32-bit
// valid/ready beats into staged 256-bit writes with a one-hot strobe, and word reads.
module host_bus_bridge #(
    parameter int              DATA_W  = 32,
    parameter int              BUS_W   = 256,
    parameter int              NREG    = 16,
    parameter logic [NREG-1:0] RO_MASK = 16'h8A24
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   cmd_valid,
    output logic                                   cmd_ready,
    input  logic                                   cmd_write,
    input  logic [$clog2(NREG)-1:0]                cmd_addr,
    input  logic [$clog2(BUS_W/DATA_W)-1:0]        cmd_word,
    input  logic                                   cmd_last,
    input  logic [DATA_W-1:0]                      cmd_data,
    output logic                                   rsp_valid,
    input  logic                                   rsp_ready,
    output logic [DATA_W-1:0]                      rsp_data,
    output logic                                   wr_err,
    output logic [NREG-1:0]                        writeEnable,
    output logic [BUS_W-1:0]                       writeBus,
    output logic [$clog2(NREG)-1:0]                selectRead,
    input  logic [BUS_W-1:0]                       dataOut
);

    localparam int NWORDS = BUS_W / DATA_W;
    localparam int WW     = $clog2(NWORDS);

    typedef enum logic [1:0] {
        IDLE,
        COMMIT,
        RSEL,
        RSP
    } state_t;

    state_t                        state;
    logic [NWORDS-1:0][DATA_W-1:0] stage;
    logic [WW-1:0]                 rd_word;
    logic                          settled;

    // The stage buffer is itself a register, so writeBus needs no extra copy.
    assign writeBus  = stage;
    assign cmd_ready = (state == IDLE) && !reset;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            stage       <= '0;
            rd_word     <= '0;
            settled     <= 1'b0;
            writeEnable <= '0;
            wr_err      <= 1'b0;
            selectRead  <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_write) begin
                            stage[cmd_word] <= cmd_data;
                            if (cmd_last) begin
                                // Strobe is launched on the accepting edge so it spans exactly COMMIT.
                                state       <= COMMIT;
                                wr_err      <= RO_MASK[cmd_addr];
                                writeEnable <= RO_MASK[cmd_addr] ? '0
                                             : ({{(NREG-1){1'b0}}, 1'b1} << cmd_addr);
                            end
                        end else begin
                            selectRead <= cmd_addr;
                            rd_word    <= cmd_word;
                            settled    <= 1'b0;
                            state      <= RSEL;
                        end
                    end
                end
                COMMIT: begin
                    writeEnable <= '0;
                    wr_err      <= 1'b0;
                    stage       <= '0;
                    state       <= IDLE;
                end
                RSEL: begin
                    // One full cycle with selectRead stable before dataOut is sampled.
                    if (!settled) begin
                        settled <= 1'b1;
                    end else begin
                        rsp_data  <= dataOut[DATA_W*rd_word +: DATA_W];
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
